// File: rtl/mmio_arbiter.sv
// mmio_arbiter: lets NUM_HOSTS upstream MMIO hosts share one downstream MMIO
// device port. The read and write channels are arbitrated independently. Each
// channel has its own round-robin grant FSM and its own watchdog. The watchdog
// completes a stalled transaction with an error response.
//
// Ports:
//   clock, reset                 system clock; asynchronous active-low reset
//   host_read_req/index          per-host read request and packed word index
//   host_read_ack/data           per-host read ack pulse; shared read data
//   host_write_req/index/data    per-host write request, packed index and data
//   host_write_ack               per-host write ack pulse
//   device_read_*                downstream read request/index, ack/data
//   device_write_*               downstream write request/index/data, ack
//   read_timeout/write_timeout   sticky forced-completion flags
//   clear_timeout                synchronous clear of both sticky flags

// One arbitration channel: round-robin grant FSM, watchdog and sticky flag.
module mmio_arbiter_chan #(
    parameter int NUM_HOSTS      = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int GW             = $clog2(NUM_HOSTS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_HOSTS-1:0] host_req,
    input  logic                 dev_ack,
    input  logic                 clear,
    output logic                 busy,
    output logic [GW-1:0]        grant,
    output logic [NUM_HOSTS-1:0] host_ack,
    output logic                 timeout_flag
);
    localparam int            CW        = $clog2(TIMEOUT_CYCLES);
    localparam int            SW        = GW + 1;
    localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] HOSTS_SW  = SW'(NUM_HOSTS);
    localparam logic [GW-1:0] LAST_HOST = GW'(NUM_HOSTS - 1);
    localparam logic          ST_IDLE   = 1'b0;
    localparam logic          ST_BUSY   = 1'b1;

    logic          state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] wdog_q, wdog_d;
    logic          flag_q, flag_d;
    logic [SW-1:0] cand;
    logic          found;
    logic          expire;
    logic          done;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        wdog_d   = wdog_q;
        flag_d   = flag_q;
        host_ack = '0;
        cand     = '0;
        found    = 1'b0;
        expire   = 1'b0;
        done     = 1'b0;
        if (state_q == ST_IDLE) begin
            // Scan ptr, ptr+1, ... modulo NUM_HOSTS. The first hit wins.
            // The extra sum bit keeps the wrap correct for non-power-of-two host counts.
            for (int i = 0; i < NUM_HOSTS; i++) begin
                cand = {1'b0, ptr_q} + SW'(i);
                if (cand >= HOSTS_SW) begin
                    cand = cand - HOSTS_SW;
                end
                if (!found && host_req[cand[GW-1:0]]) begin
                    found   = 1'b1;
                    grant_d = cand[GW-1:0];
                end
            end
            if (found) begin
                state_d = ST_BUSY;
                wdog_d  = '0;
            end
        end else begin
            // A real device ack in the expiry cycle takes precedence over the forced completion.
            expire = (wdog_q == WDOG_LAST) && !dev_ack;
            done   = dev_ack || expire;
            if (done) begin
                state_d           = ST_IDLE;
                ptr_d             = (grant_q == LAST_HOST) ? '0 : grant_q + 1'b1;
                host_ack[grant_q] = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
            if (expire) begin
                flag_d = 1'b1;
            end
        end
        if (clear) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            flag_q  <= flag_d;
        end
    end

    assign busy         = (state_q == ST_BUSY);
    assign grant        = grant_q;
    assign timeout_flag = flag_q;
endmodule

module mmio_arbiter #(
    parameter int                    NUM_HOSTS      = 2,
    parameter int                    INDEX_WIDTH    = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = 32'hDEAD_BEEF
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_HOSTS-1:0]             host_read_req,
    input  logic [NUM_HOSTS*INDEX_WIDTH-1:0] host_read_index,
    output logic [NUM_HOSTS-1:0]             host_read_ack,
    output logic [DATA_WIDTH-1:0]            host_read_data,
    input  logic [NUM_HOSTS-1:0]             host_write_req,
    input  logic [NUM_HOSTS*INDEX_WIDTH-1:0] host_write_index,
    input  logic [NUM_HOSTS*DATA_WIDTH-1:0]  host_write_data,
    output logic [NUM_HOSTS-1:0]             host_write_ack,
    output logic                             device_read_req,
    output logic [INDEX_WIDTH-1:0]           device_read_index,
    input  logic                             device_read_ack,
    input  logic [DATA_WIDTH-1:0]            device_read_data,
    output logic                             device_write_req,
    output logic [INDEX_WIDTH-1:0]           device_write_index,
    output logic [DATA_WIDTH-1:0]            device_write_data,
    input  logic                             device_write_ack,
    output logic                             read_timeout,
    output logic                             write_timeout,
    input  logic                             clear_timeout
);
    localparam int GW = $clog2(NUM_HOSTS);

    logic          rd_busy, wr_busy;
    logic [GW-1:0] rd_grant, wr_grant;

    mmio_arbiter_chan #(
        .NUM_HOSTS(NUM_HOSTS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .GW(GW)
    ) u_rd_chan (
        .clock(clock), .reset(reset), .host_req(host_read_req),
        .dev_ack(device_read_ack), .clear(clear_timeout), .busy(rd_busy),
        .grant(rd_grant), .host_ack(host_read_ack), .timeout_flag(read_timeout)
    );

    mmio_arbiter_chan #(
        .NUM_HOSTS(NUM_HOSTS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .GW(GW)
    ) u_wr_chan (
        .clock(clock), .reset(reset), .host_req(host_write_req),
        .dev_ack(device_write_ack), .clear(clear_timeout), .busy(wr_busy),
        .grant(wr_grant), .host_ack(host_write_ack), .timeout_flag(write_timeout)
    );

    // Device-side outputs follow the granted host and are zero while idle.
    always_comb begin
        device_read_req    = rd_busy;
        device_read_index  = '0;
        device_write_req   = wr_busy;
        device_write_index = '0;
        device_write_data  = '0;
        host_read_data     = '0;
        for (int h = 0; h < NUM_HOSTS; h++) begin
            if (rd_busy && (rd_grant == GW'(h))) begin
                device_read_index = host_read_index[h*INDEX_WIDTH +: INDEX_WIDTH];
            end
            if (wr_busy && (wr_grant == GW'(h))) begin
                device_write_index = host_write_index[h*INDEX_WIDTH +: INDEX_WIDTH];
                device_write_data  = host_write_data[h*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        // A host ack without a device ack can only be a forced completion.
        if (|host_read_ack) begin
            host_read_data = device_read_ack ? device_read_data : ERROR_DATA;
        end
    end
endmodule
